// File: rtl/hamming_frame_rx.sv
// hamming_frame_rx: serial Hamming(7,4) receiver. Corrects single-bit errors
// per codeword, packs nibbles (nibble 0 first, into the LSBs) into a
// width-bit word and presents it with a valid/ready handshake together with
// the number of codewords that had a nonzero syndrome.
module hamming_frame_rx #(
   parameter int width = 64
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             serial_in,
   input  logic                             bit_valid,
   input  logic                             sof,
   input  logic                             data_ready,
   output logic [width-1:0]                 data_out,
   output logic                             data_valid,
   output logic [$clog2(width/4+1)-1:0]     corr_count,
   output logic                             frame_err,
   output logic                             busy
);

   localparam int BLOCKS = width / 4;
   localparam int CNT_W  = $clog2(BLOCKS + 1);
   localparam int NIB_W  = (BLOCKS > 1) ? $clog2(BLOCKS) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RECV = 2'd1;
   localparam logic [1:0] HOLD = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [5:0]        cw_q, cw_d;       // first six bits of the codeword, oldest in bit 0
   logic [2:0]        cnt_q, cnt_d;     // bit position within the current codeword
   logic [NIB_W-1:0]  nib_q, nib_d;     // nibble slot being filled
   logic [width-1:0]  data_q, data_d;
   logic [CNT_W-1:0]  corr_q, corr_d;
   logic              err_q, err_d;
   logic              valid_q, valid_d;
   logic              busy_q, busy_d;

   logic              start;            // accept this beat as d0 of codeword 0
   logic              shift;            // accept this beat as a continuation bit
   logic [4:0]        dec;              // {syndrome nonzero, corrected nibble}

   // Syndrome decode of a full codeword {p3,p2,p1,d3,d2,d1,d0}.
   function automatic logic [4:0] decode(input logic [6:0] c);
      logic [2:0] s;
      logic [3:0] d;
      d    = c[3:0];
      s[0] = c[4] ^ c[3] ^ c[2] ^ c[0];
      s[1] = c[5] ^ c[3] ^ c[1] ^ c[0];
      s[2] = c[6] ^ c[2] ^ c[1] ^ c[0];
      case (s)
         3'b111:  d[0] = ~d[0];
         3'b110:  d[1] = ~d[1];
         3'b101:  d[2] = ~d[2];
         3'b011:  d[3] = ~d[3];
         default: ;  // parity-bit error or clean: data untouched
      endcase
      return {|s, d};
   endfunction

   // Next-state, framing and decode logic.
   always_comb begin
      state_d = state_q;
      cw_d    = cw_q;
      cnt_d   = cnt_q;
      nib_d   = nib_q;
      data_d  = data_q;
      corr_d  = corr_q;
      err_d   = 1'b0;
      start   = 1'b0;
      shift   = 1'b0;
      dec     = '0;

      case (state_q)
         IDLE: begin
            if (bit_valid) begin
               if (sof) start = 1'b1;
               else     err_d = 1'b1;
            end
         end
         RECV: begin
            if (bit_valid) begin
               if (sof) begin
                  err_d = 1'b1;   // abort; this bit opens a new frame
                  start = 1'b1;
               end else begin
                  shift = 1'b1;
               end
            end
         end
         HOLD: begin
            if (data_ready) begin
               state_d = IDLE;
               if (bit_valid && sof) start = 1'b1;
               else if (bit_valid)   err_d = 1'b1;
            end else if (bit_valid) begin
               err_d = 1'b1;      // word not yet taken: any beat is dropped
            end
         end
         default: state_d = IDLE;
      endcase

      if (start) begin
         state_d = RECV;
         cw_d    = {serial_in, cw_q[5:1]};
         cnt_d   = 3'd1;
         nib_d   = '0;
         corr_d  = '0;
         data_d  = '0;
      end

      if (shift) begin
         cw_d = {serial_in, cw_q[5:1]};
         if (cnt_q == 3'd6) begin
            dec = decode({serial_in, cw_q});
            data_d[4*nib_q +: 4] = dec[3:0];
            if (dec[4] && corr_q != CNT_W'(BLOCKS)) corr_d = corr_q + 1'b1;
            cnt_d = 3'd0;
            if (nib_q == NIB_W'(BLOCKS - 1)) begin
               nib_d   = '0;
               state_d = HOLD;
            end else begin
               nib_d = nib_q + 1'b1;
            end
         end else begin
            cnt_d = cnt_q + 3'd1;
         end
      end

      valid_d = (state_d == HOLD);
      busy_d  = (state_d == RECV);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cw_q    <= '0;
         cnt_q   <= '0;
         nib_q   <= '0;
         data_q  <= '0;
         corr_q  <= '0;
         err_q   <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cw_q    <= cw_d;
         cnt_q   <= cnt_d;
         nib_q   <= nib_d;
         data_q  <= data_d;
         corr_q  <= corr_d;
         err_q   <= err_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
      end
   end

   assign data_out   = data_q;
   assign data_valid = valid_q;
   assign corr_count = corr_q;
   assign frame_err  = err_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_hamming_frame_rx.sv
// Bench for hamming_frame_rx at width=8: directed frames, a frame-level
// nearest-codeword model checked every cycle, plus literal expectations.
module tb_hamming_frame_rx;

   localparam int W      = 8;
   localparam int BLOCKS = W / 4;

   localparam logic [6:0] CW5   = 7'b0100101;  // wire order d0..p3 = 1,0,1,0,0,1,0
   localparam logic [6:0] CWA   = 7'b1011010;  // wire order 0,1,0,1,1,0,1
   localparam logic [6:0] CW5D2 = 7'b0100001;  // d2 flipped
   localparam logic [6:0] CW5P1 = 7'b0110101;  // p1 flipped
   localparam logic [6:0] CWAP3 = 7'b0011010;  // p3 flipped

   logic         clk = 1'b0;
   logic         rst;
   logic         serial_in = 1'b0;
   logic         bit_valid = 1'b0;
   logic         sof = 1'b0;
   logic         data_ready = 1'b1;
   logic [W-1:0] data_out;
   logic         data_valid;
   logic [1:0]   corr_count;
   logic         frame_err;
   logic         busy;

   int checks = 0;
   int failures = 0;
   int err_seen = 0;
   int vld_cycles = 0;

   hamming_frame_rx #(.width(W)) dut (
      .clk(clk), .rst(rst), .serial_in(serial_in), .bit_valid(bit_valid),
      .sof(sof), .data_ready(data_ready), .data_out(data_out),
      .data_valid(data_valid), .corr_count(corr_count),
      .frame_err(frame_err), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- model: frame-level, nearest codeword ----------------
   function automatic logic [6:0] enc(input logic [3:0] n);
      return {n[0]^n[1]^n[2], n[0]^n[1]^n[3], n[0]^n[2]^n[3], n};
   endfunction

   // {received word was not a codeword, decoded nibble}
   function automatic logic [4:0] nearest(input logic [6:0] r);
      for (int n = 0; n < 16; n++)
         if ($countones(enc(4'(n)) ^ r) <= 1) return {enc(4'(n)) != r, 4'(n)};
      return 5'b0;
   endfunction

   logic         mq[$];
   logic         m_recv = 1'b0, m_hold = 1'b0;
   logic [W-1:0] exp_data = '0;
   logic [1:0]   exp_corr = '0;
   logic         exp_valid = 1'b0, exp_err = 1'b0, exp_busy = 1'b0;

   initial begin
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) begin
            mq.delete();
            m_recv = 0; m_hold = 0;
            exp_data = '0; exp_corr = '0; exp_err = 0;
         end else begin
            logic start;
            start = 0; exp_err = 0;
            if (m_hold) begin
               if (data_ready) begin
                  m_hold = 0;
                  if (bit_valid && sof) start = 1;
                  else if (bit_valid) exp_err = 1;
               end else if (bit_valid) exp_err = 1;
            end else if (m_recv) begin
               if (bit_valid && sof) begin exp_err = 1; start = 1; end
               else if (bit_valid) mq.push_back(serial_in);
            end else if (bit_valid) begin
               if (sof) start = 1; else exp_err = 1;
            end
            if (start) begin
               mq.delete();
               mq.push_back(serial_in);
               m_recv = 1;
            end
            if (m_recv && mq.size() == 7*BLOCKS) begin
               exp_data = '0; exp_corr = '0;
               for (int b = 0; b < BLOCKS; b++) begin
                  logic [6:0] r;
                  logic [4:0] nd;
                  for (int i = 0; i < 7; i++) r[i] = mq[7*b+i];
                  nd = nearest(r);
                  exp_data[4*b +: 4] = nd[3:0];
                  exp_corr += 2'(nd[4]);
               end
               m_recv = 0; m_hold = 1;
            end
         end
         exp_valid = m_hold;
         exp_busy  = m_recv;
      end
   end

   // Per-cycle compare of DUT against the model.
   initial begin
      forever begin
         @(posedge clk);
         #2;
         chk("cyc_valid", data_valid, exp_valid);
         chk("cyc_err",   frame_err,  exp_err);
         chk("cyc_busy",  busy,       exp_busy);
         if (exp_valid) begin
            chk("cyc_data", data_out,   exp_data);
            chk("cyc_corr", corr_count, exp_corr);
         end
      end
   end

   // Pulse/valid counters sampled away from the edge.
   initial begin
      forever begin
         @(negedge clk);
         if (frame_err)  err_seen++;
         if (data_valid) vld_cycles++;
      end
   end

   // ---------------- stimulus ----------------
   task automatic beat(input logic b, input logic s);
      @(negedge clk);
      bit_valid = 1'b1; serial_in = b; sof = s;
   endtask

   task automatic gap(input int n);
      repeat (n) begin
         @(negedge clk);
         bit_valid = 1'b0; sof = 1'b0;
      end
   endtask

   task automatic send_cw(input logic [6:0] c, input logic first);
      for (int i = 0; i < 7; i++) beat(c[i], first && i == 0);
   endtask

   task automatic frame_done(input string nm, input logic [7:0] ed, input logic [1:0] ec);
      @(negedge clk);
      bit_valid = 1'b0; sof = 1'b0;
      chk({nm, "_valid"}, data_valid, 1'b1);
      chk({nm, "_data"},  data_out,   ed);
      chk({nm, "_corr"},  corr_count, ec);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int e0, v0;
      logic [6:0] t;
      rst = 1'b1;
      #1 rst = 1'b0;

      // model pins
      t = CW5D2; chk("pin_d2",  nearest(t), 5'h15);
      t = CWAP3; chk("pin_p3",  nearest(t), 5'h1A);
      t = CWA;   chk("pin_cln", nearest(t), 5'h0A);

      repeat (3) @(negedge clk);
      chk("rst_data",  data_out,   8'h00);
      chk("rst_valid", data_valid, 1'b0);
      chk("rst_corr",  corr_count, 2'd0);
      chk("rst_err",   frame_err,  1'b0);
      chk("rst_busy",  busy,       1'b0);
      rst = 1'b1;
      gap(2);

      // clean frame
      v0 = vld_cycles;
      send_cw(CW5, 1'b1); send_cw(CWA, 1'b0);
      frame_done("clean", 8'hA5, 2'd0);
      gap(3);
      chk("clean_vld_cycles", vld_cycles - v0, 1);

      // stray beat in IDLE
      e0 = err_seen;
      beat(1'b1, 1'b0); gap(2);
      chk("idle_stray_err", err_seen - e0, 1);

      // data-bit error, with a gap between codewords
      send_cw(CW5D2, 1'b1); gap(2); send_cw(CWA, 1'b0);
      frame_done("d2err", 8'hA5, 2'd1);
      gap(2);

      // parity-bit errors in both codewords: count reaches blocks
      send_cw(CW5P1, 1'b1); send_cw(CWAP3, 1'b0);
      frame_done("perr", 8'hA5, 2'd2);
      gap(2);

      // abort: sof on beat 10 starts a fresh frame
      e0 = err_seen; v0 = vld_cycles;
      send_cw(CW5, 1'b1); beat(CWA[0], 1'b0); beat(CWA[1], 1'b0);
      send_cw(CW5, 1'b1); send_cw(CWA, 1'b0);
      frame_done("abort", 8'hA5, 2'd0);
      gap(2);
      chk("abort_err_pulses", err_seen - e0, 1);
      chk("abort_vld_cycles", vld_cycles - v0, 1);

      // backpressure with stray beats, then ready together with next sof
      data_ready = 1'b0;
      send_cw(CWA, 1'b1); send_cw(CW5, 1'b0);
      frame_done("bp1", 8'h5A, 2'd0);
      e0 = err_seen;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         bit_valid = (k % 2 == 0); sof = 1'b0; serial_in = 1'b1;
         chk("bp_hold_data",  data_out,   8'h5A);
         chk("bp_hold_valid", data_valid, 1'b1);
      end
      @(negedge clk);
      data_ready = 1'b1; bit_valid = 1'b1; sof = 1'b1; serial_in = CW5[0];
      for (int i = 1; i < 7; i++) beat(CW5[i], 1'b0);
      send_cw(CWA, 1'b0);
      frame_done("bp2", 8'hA5, 2'd0);
      gap(2);
      chk("bp_err_pulses", err_seen - e0, 3);

      // reset mid-frame
      e0 = err_seen;
      for (int i = 0; i < 5; i++) beat(CW5[i], i == 0);
      @(negedge clk);
      bit_valid = 1'b0; sof = 1'b0;
      chk("mid_busy", busy, 1'b1);
      rst = 1'b0;
      #1;
      chk("mrst_data",  data_out,   8'h00);
      chk("mrst_valid", data_valid, 1'b0);
      chk("mrst_corr",  corr_count, 2'd0);
      chk("mrst_err",   frame_err,  1'b0);
      chk("mrst_busy",  busy,       1'b0);
      @(negedge clk);
      rst = 1'b1;
      gap(1);
      send_cw(CW5, 1'b1); send_cw(CWA, 1'b0);
      frame_done("post_rst", 8'hA5, 2'd0);
      gap(3);
      chk("mrst_err_pulses", err_seen - e0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
